irq_controller: RTL and testbench
=================================

IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter VEC_BASE SHALL be 16 bits, default 16'h0000, and is the vector returned for source 0.
REQ-003 clk  in  1  system clock (50 MHz); all state SHALL update on posedge clk.
REQ-004 rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
REQ-005 irq  in  8  device interrupt lines; bit 0 has the highest priority.
REQ-006 intack  in  1  CPU interrupt acknowledge, level.
REQ-007 wr_en  in  1  CPU register write strobe.
REQ-008 addr  in  2  register select: 0 MASK, 1 PENDING, 2 EOI, 3 STATUS.
REQ-009 wdata  in  16  CPU write data.
REQ-010 rdata  out  16  register read data, combinational on addr.
REQ-011 int_req  out  1  interrupt request to the CPU, registered.
REQ-012 vector  out  16  VEC_BASE + winning source index, registered.
REQ-013 src_ack  out  8  one-cycle acknowledge pulse to the serviced device.

Function
REQ-014 Edge detect: irq_prev SHALL register irq each cycle; pending[i] SHALL set on the cycle where irq[i]=1 and irq_prev[i]=0.
REQ-015 MASK register (8 bits): a write SHALL load wdata[7:0]; bit=1 enables the source; read returns {8'h00, mask}.
REQ-016 PENDING register: a write SHALL clear the bits where wdata[i]=1 (write-1-to-clear); read returns {8'h00, pending}.
REQ-017 EOI: any write to addr 2 SHALL clear the lowest-indexed set bit of in_service; with in_service=0 it SHALL have no effect; read returns 16'h0000.
REQ-018 STATUS register SHALL be read-only and return {in_service, pending}; writes to it SHALL be ignored.
REQ-019 Eligibility: eligible[i] = pending[i] & mask[i] & (i < index of the lowest set in_service bit, or in_service=0); this nests strictly by priority.
REQ-020 Winner SHALL be the lowest-indexed eligible bit.
REQ-021 The FSM SHALL have three states: IDLE, REQ, ACK.
REQ-022 IDLE: if any bit is eligible, the FSM SHALL go to REQ, register the winner, and set int_req=1 and vector=VEC_BASE+winner on the next edge.
REQ-023 REQ arbitration: the winner SHALL be re-arbitrated every cycle, so a higher-priority arrival updates vector before intack.
REQ-024 REQ empty: if nothing is eligible (source masked or W1C-cleared), the FSM SHALL return to IDLE with int_req=0.
REQ-025 REQ acknowledge: when intack=1, the FSM SHALL go to ACK and, on that edge, clear pending[winner], set in_service[winner], pulse src_ack[winner] for exactly 1 cycle, and set int_req=0; vector SHALL hold through ACK.
REQ-026 ACK: the FSM SHALL remain in ACK while intack=1 and go to IDLE on intack=0; no new request SHALL be issued from ACK.
REQ-027 intack asserted in IDLE SHALL be ignored.
REQ-028 Simultaneous pending events: a set (edge) SHALL win over a clear (W1C or acknowledge) on the same bit in the same cycle.
REQ-029 Simultaneous in_service events: in_service_next = (in_service & ~eoi_clear) | ack_set, with eoi_clear computed from the current in_service.
REQ-030 A mask write SHALL take effect on eligibility in the cycle following the write.
REQ-031 Latency: from an irq rising edge (pending set at edge N) to int_req=1 SHALL be 2 clocks when the FSM is in IDLE.

Reset
REQ-032 When rst_n=0 at posedge clk, the block SHALL set mask=8'h00, pending=0, in_service=0, irq_prev=0, state=IDLE, int_req=0, vector=VEC_BASE, and src_ack=0.
REQ-033 Reset mid-handshake (REQ or ACK) SHALL abort to IDLE with no src_ack pulse.
REQ-034 An irq line held high through reset release SHALL register as an edge in the first post-reset cycle.

Verification
REQ-035 Basic request: mask=8'h02, pulse irq[1] -> int_req=1 two clocks after the pending edge and vector=16'h0001; intack=1 -> src_ack=8'h02 for 1 cycle, pending=0, STATUS=16'h0200.
REQ-036 Priority: irq[3] and irq[5] rise together with mask=8'hFF -> vector=16'h0003; after acknowledge and EOI, a second request appears with vector=16'h0005.
REQ-037 Nesting: in_service=8'h04 -> irq[6] is held pending with int_req=0; irq[0] is requested (vector=16'h0000); the first EOI clears bit 0, leaving STATUS in_service=8'h04.
REQ-038 Preemption in REQ: winner is 4, then irq[1] rises before intack -> vector changes to 16'h0001 and acknowledge pulses src_ack[1].
REQ-039 Boundaries: an edge and a W1C on the same bit in the same cycle -> pending stays 1; EOI with in_service=0 -> no change; masking the only pending source during REQ -> int_req=0 and FSM in IDLE.
REQ-040 Reset: rst_n=0 during ACK -> next cycle int_req=0, src_ack=0, and every STATUS read returns 16'h0000.

Source files
------------

// File: rtl/irq_controller.sv
// ---------------------------------------------------------------------------
// irq_controller
//
// Eight-source prioritised interrupt controller with nested in-service
// tracking. Rising edges on irq latch into PENDING. Enabled pending sources
// that outrank every in-service source compete, and the lowest index wins.
// The winner is presented to the CPU as int_req/vector, and the CPU
// acknowledges it with a level intack handshake. EOI writes retire the
// highest-priority in-service source.
//
// Ports
//   clk      in   1   system clock, all state updates on the rising edge
//   rst_n    in   1   synchronous active-low reset
//   irq      in   8   device interrupt lines, bit 0 has the highest priority
//   intack   in   1   CPU interrupt acknowledge (level)
//   wr_en    in   1   CPU register write strobe
//   addr     in   2   register select: 0 MASK, 1 PENDING, 2 EOI, 3 STATUS
//   wdata    in  16   CPU write data
//   rdata    out 16   register read data, combinational on addr
//   int_req  out  1   registered interrupt request to the CPU
//   vector   out 16   registered VEC_BASE + winning source index
//   src_ack  out  8   one-cycle acknowledge pulse to the serviced device
// ---------------------------------------------------------------------------
module irq_controller #(
  parameter logic [15:0] VEC_BASE = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  irq,
  input  logic        intack,
  input  logic        wr_en,
  input  logic [1:0]  addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        int_req,
  output logic [15:0] vector,
  output logic [7:0]  src_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_MASK    = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_EOI     = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  state_t     state;
  logic [7:0] irq_prev;
  logic [7:0] pending;
  logic [7:0] mask;
  logic [7:0] in_service;

  logic [7:0] irq_rise;
  logic [7:0] isr_lowest;   // one-hot: highest-priority source in service
  logic [7:0] prio_window;  // sources allowed to nest above in_service
  logic [7:0] eligible;
  logic [7:0] win_onehot;
  logic [2:0] win_idx;
  logic       any_eligible;
  logic [7:0] w1c;
  logic [7:0] eoi_clear;
  logic [7:0] ack_set;
  logic       do_ack;

  // Upper write-data bits carry no register state.
  logic unused_wdata;
  assign unused_wdata = ^wdata[15:8];

  // Arbitration and register-side decode.
  // NOTE: every signal gets a value before any conditional update so that
  // always_comb never has a path that holds a value, which would infer latches.
  always_comb begin
    irq_rise     = irq & ~irq_prev;
    isr_lowest   = in_service & (~in_service + 8'd1);
    // All bits below the lowest in-service bit; everything when idle.
    prio_window  = (in_service == 8'h00) ? 8'hFF : (isr_lowest - 8'd1);
    eligible     = pending & mask & prio_window;
    win_onehot   = eligible & (~eligible + 8'd1);
    any_eligible = |eligible;

    win_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (eligible[i]) win_idx = 3'(i);
    end

    w1c       = (wr_en && addr == ADDR_PENDING) ? wdata[7:0] : 8'h00;
    eoi_clear = (wr_en && addr == ADDR_EOI) ? isr_lowest : 8'h00;

    // Acknowledge only a request the CPU can actually see.
    do_ack  = (state == REQ) && int_req && intack && any_eligible;
    ack_set = do_ack ? win_onehot : 8'h00;
  end

  always_comb begin
    rdata = 16'h0000;
    case (addr)
      ADDR_MASK:    rdata = {8'h00, mask};
      ADDR_PENDING: rdata = {8'h00, pending};
      ADDR_EOI:     rdata = 16'h0000;
      ADDR_STATUS:  rdata = {in_service, pending};
      default:      rdata = 16'h0000;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order in this block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      irq_prev   <= 8'h00;
      pending    <= 8'h00;
      mask       <= 8'h00;
      in_service <= 8'h00;
      int_req    <= 1'b0;
      vector     <= VEC_BASE;
      src_ack    <= 8'h00;
    end else begin
      irq_prev <= irq;
      // A new edge beats a same-cycle clear on the same bit.
      pending    <= (pending & ~w1c & ~ack_set) | irq_rise;
      in_service <= (in_service & ~eoi_clear) | ack_set;
      src_ack    <= ack_set;

      if (wr_en && addr == ADDR_MASK) mask <= wdata[7:0];

      case (state)
        IDLE: begin
          int_req <= 1'b0;
          if (any_eligible) begin
            state  <= REQ;
            vector <= VEC_BASE + {13'd0, win_idx};
          end
        end
        REQ: begin
          if (!any_eligible) begin
            state   <= IDLE;
            int_req <= 1'b0;
          end else begin
            // Re-arbitrate every cycle so a late higher-priority arrival
            // is what the CPU ends up acknowledging.
            vector <= VEC_BASE + {13'd0, win_idx};
            if (do_ack) begin
              state   <= ACK;
              int_req <= 1'b0;
            end else begin
              int_req <= 1'b1;
            end
          end
        end
        ACK: begin
          int_req <= 1'b0;
          if (!intack) state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          int_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// ---------------------------------------------------------------------------
// tb_irq_controller
//
// Directed bench for irq_controller. Expected values go into a scoreboard
// queue as stimulus is driven and are popped when the matching DUT output is
// sampled (1 ns after the rising edge).
// ---------------------------------------------------------------------------
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  irq;
  logic        intack;
  logic        wr_en;
  logic [1:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        int_req;
  logic [15:0] vector;
  logic [7:0]  src_ack;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } sb_t;

  sb_t sb_q[$];

  irq_controller dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .irq     (irq),
    .intack  (intack),
    .wr_en   (wr_en),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .int_req (int_req),
    .vector  (vector),
    .src_ack (src_ack)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    wdata = 16'h0000;
  endtask

  task automatic push(input string t, input logic [15:0] e);
    sb_t item;
    item.tag = t;
    item.exp = e;
    sb_q.push_back(item);
  endtask

  task automatic check(input logic [15:0] obs);
    sb_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %h with no expected entry", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic chk(input string t, input logic [15:0] obs, input logic [15:0] e);
    push(t, e);
    check(obs);
  endtask

  task automatic rd_chk(input string t, input logic [1:0] a, input logic [15:0] e);
    addr = a;
    #1;
    chk(t, rdata, e);
  endtask

  // Step until int_req rises or the budget runs out; n is cycles taken.
  task automatic wait_int_req(input int max, output int n);
    n = 0;
    while (!int_req && n < max) begin
      step();
      n++;
    end
  endtask

  initial begin
    int lat;
    rst_n  = 1'b0;
    irq    = 8'h00;
    intack = 1'b0;
    wr_en  = 1'b0;
    addr   = 2'd0;
    wdata  = 16'h0000;

    // ---------------- reset state ----------------
    steps(2);
    chk("rst_int_req", 16'(int_req), 16'h0000);
    chk("rst_vector", vector, 16'h0000);
    chk("rst_src_ack", 16'(src_ack), 16'h0000);
    rd_chk("rst_status", 2'd3, 16'h0000);
    rd_chk("rst_mask", 2'd0, 16'h0000);
    rst_n = 1'b1;
    step();

    // ---------------- basic request ----------------
    wr(2'd0, 16'h0002);
    rd_chk("t1_mask_rd", 2'd0, 16'h0002);
    irq = 8'h02;
    step();                               // pending edge
    rd_chk("t1_pending", 2'd1, 16'h0002);
    push("t1_int_req_early", 16'h0000);
    push("t1_int_req", 16'h0001);
    push("t1_vector", 16'h0001);
    step();
    check(16'(int_req));
    step();
    check(16'(int_req));
    check(vector);
    irq    = 8'h00;
    intack = 1'b1;
    step();
    chk("t1_src_ack", 16'(src_ack), 16'h0002);
    chk("t1_int_req_ack", 16'(int_req), 16'h0000);
    chk("t1_vector_hold", vector, 16'h0001);
    rd_chk("t1_status", 2'd3, 16'h0200);
    step();
    chk("t1_src_ack_pulse", 16'(src_ack), 16'h0000);
    intack = 1'b0;
    step();
    wr(2'd2, 16'h0000);
    rd_chk("t1_status_eoi", 2'd3, 16'h0000);

    // ---------------- priority ----------------
    wr(2'd0, 16'h00FF);
    irq = 8'h28;
    step();
    irq = 8'h00;
    wait_int_req(10, lat);
    chk("t2_latency", 16'(lat), 16'd2);
    chk("t2_vector_first", vector, 16'h0003);
    intack = 1'b1;
    step();
    chk("t2_src_ack3", 16'(src_ack), 16'h0008);
    intack = 1'b0;
    step();
    rd_chk("t2_status", 2'd3, 16'h0820);
    wr(2'd2, 16'h0000);
    wait_int_req(10, lat);
    chk("t2_latency2", 16'(lat), 16'd2);
    chk("t2_vector_second", vector, 16'h0005);
    intack = 1'b1;
    step();
    chk("t2_src_ack5", 16'(src_ack), 16'h0020);
    intack = 1'b0;
    step();
    wr(2'd2, 16'h0000);
    rd_chk("t2_status_end", 2'd3, 16'h0000);

    // ---------------- nesting ----------------
    irq = 8'h04;
    step();
    irq = 8'h00;
    steps(2);
    intack = 1'b1;
    step();
    intack = 1'b0;
    step();
    rd_chk("t3_isr2", 2'd3, 16'h0400);
    irq = 8'h40;
    steps(3);
    chk("t3_irq6_blocked", 16'(int_req), 16'h0000);
    rd_chk("t3_status_held", 2'd3, 16'h0440);
    irq = 8'h01;
    step();
    irq = 8'h00;
    steps(2);
    chk("t3_int_req0", 16'(int_req), 16'h0001);
    chk("t3_vector0", vector, 16'h0000);
    intack = 1'b1;
    step();
    chk("t3_src_ack0", 16'(src_ack), 16'h0001);
    intack = 1'b0;
    step();
    rd_chk("t3_status_nested", 2'd3, 16'h0540);
    wr(2'd2, 16'h0000);
    rd_chk("t3_status_eoi", 2'd3, 16'h0440);
    chk("t3_no_req_after_eoi", 16'(int_req), 16'h0000);
    wr(2'd0, 16'h0000);
    wr(2'd2, 16'h0000);
    wr(2'd1, 16'h00FF);
    rd_chk("t3_status_clean", 2'd3, 16'h0000);

    // ---------------- preemption in REQ ----------------
    wr(2'd0, 16'h00FF);
    irq = 8'h10;
    step();
    steps(2);
    chk("t4_vector4", vector, 16'h0004);
    irq = 8'h12;
    step();
    chk("t4_vector_pre", vector, 16'h0004);
    step();
    chk("t4_vector1", vector, 16'h0001);
    chk("t4_int_req", 16'(int_req), 16'h0001);
    irq    = 8'h00;
    intack = 1'b1;
    step();
    chk("t4_src_ack1", 16'(src_ack), 16'h0002);
    intack = 1'b0;
    step();
    rd_chk("t4_status", 2'd3, 16'h0210);
    wr(2'd0, 16'h0000);
    wr(2'd2, 16'h0000);
    wr(2'd1, 16'h00FF);
    rd_chk("t4_status_clean", 2'd3, 16'h0000);

    // ---------------- boundaries ----------------
    irq = 8'h08;
    wr(2'd1, 16'h0008);                   // edge and W1C on bit 3 together
    irq = 8'h00;
    rd_chk("t5_set_wins", 2'd1, 16'h0008);
    wr(2'd2, 16'h0000);                   // EOI with nothing in service
    rd_chk("t5_eoi_noop", 2'd3, 16'h0008);
    wr(2'd1, 16'h0008);
    rd_chk("t5_w1c", 2'd1, 16'h0000);
    wr(2'd0, 16'h00FF);
    irq = 8'h01;
    step();
    irq = 8'h00;
    steps(2);
    chk("t5_req_up", 16'(int_req), 16'h0001);
    wr(2'd0, 16'h0000);
    chk("t5_mask_lag", 16'(int_req), 16'h0001);
    step();
    chk("t5_mask_drop", 16'(int_req), 16'h0000);
    intack = 1'b1;
    step();
    chk("t5_idle_intack_ack", 16'(src_ack), 16'h0000);
    rd_chk("t5_idle_intack_status", 2'd3, 16'h0001);
    intack = 1'b0;
    wr(2'd1, 16'h00FF);
    rd_chk("t5_status_clean", 2'd3, 16'h0000);

    // ---------------- reset mid-handshake ----------------
    wr(2'd0, 16'h00FF);
    irq = 8'h04;
    steps(3);
    chk("t6_req", 16'(int_req), 16'h0001);
    intack = 1'b1;
    step();
    chk("t6_ack", 16'(src_ack), 16'h0004);
    rst_n = 1'b0;
    step();
    chk("t6_rst_int_req", 16'(int_req), 16'h0000);
    chk("t6_rst_src_ack", 16'(src_ack), 16'h0000);
    chk("t6_rst_vector", vector, 16'h0000);
    rd_chk("t6_rst_status", 2'd3, 16'h0000);
    rd_chk("t6_rst_mask", 2'd0, 16'h0000);
    rst_n  = 1'b1;
    intack = 1'b0;
    step();                               // irq[2] still high
    rd_chk("t6_held_edge", 2'd3, 16'h0004);
    wr(2'd0, 16'h00FF);
    steps(2);
    chk("t6_req2", 16'(int_req), 16'h0001);
    rst_n  = 1'b0;
    intack = 1'b1;
    step();
    chk("t6_rst_req_ack", 16'(src_ack), 16'h0000);
    chk("t6_rst_req_int", 16'(int_req), 16'h0000);
    rst_n  = 1'b1;
    intack = 1'b0;
    irq    = 8'h00;
    step();
    rd_chk("t6_status_end", 2'd3, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
